// File: rtl/miss_block_fetch_if.sv
// miss_block_fetch_if: miss request, memory read, updater handshake and statistics bundle.
interface miss_block_fetch_if #(
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic miss_req;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic busy;
    logic mem_rd_req;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic mem_rd_valid;
    logic [WORD_WIDTH-1:0] mem_rd_data;
    logic update_start;
    logic [BLOCK_SIZE_BYTE*8-1:0] block;
    logic updated;
    logic fill_done;
    logic [15:0] miss_latency;
    logic [15:0] fill_count;
    modport master (
        output miss_req, miss_addr, mem_rd_valid, mem_rd_data, updated,
        input busy, mem_rd_req, mem_rd_addr, update_start, block, fill_done, miss_latency, fill_count
    );
    modport slave (
        input miss_req, miss_addr, mem_rd_valid, mem_rd_data, updated,
        output busy, mem_rd_req, mem_rd_addr, update_start, block, fill_done, miss_latency, fill_count
    );
endinterface

// File: rtl/miss_block_fetch.sv
// miss_block_fetch: fetches a missing cache block word by word and hands it to the cache updater.
// Optional FILL_TIMEOUT_EN reissues a beat request after 256 WAIT cycles without read data.
module miss_block_fetch #(
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    miss_block_fetch_if.slave bus
);
    localparam int beats = BLOCK_SIZE_BYTE * 8 / WORD_WIDTH;
    localparam int beat_w = beats > 1 ? $clog2(beats) : 1;
    localparam logic [beat_w-1:0] last_beat = beat_w'(beats - 1);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;
    state_t state;
    logic [beat_w-1:0] beat;
`ifdef FILL_TIMEOUT_EN
    logic [7:0] timer;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat <= '0;
            bus.busy <= 1'b0;
            bus.mem_rd_req <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.update_start <= 1'b0;
            bus.block <= '0;
            bus.fill_done <= 1'b0;
            bus.miss_latency <= '0;
            bus.fill_count <= '0;
`ifdef FILL_TIMEOUT_EN
            timer <= '0;
`endif
        end else begin
            bus.mem_rd_req <= 1'b0;
            bus.fill_done <= 1'b0;
            if ((state == REQ || state == WAIT || state == WRITE) && bus.miss_latency != 16'hFFFF)
                bus.miss_latency <= bus.miss_latency + 16'd1;
            case (state)
                IDLE: if (bus.miss_req) begin
                    state <= REQ;
                    beat <= '0;
                    bus.busy <= 1'b1;
                    bus.mem_rd_req <= 1'b1;
                    bus.mem_rd_addr <= bus.miss_addr & ~ADDR_WIDTH'(BLOCK_SIZE_BYTE - 1);
                    bus.miss_latency <= '0;
                end
                REQ: begin
                    state <= WAIT;
`ifdef FILL_TIMEOUT_EN
                    timer <= '0;
`endif
                end
                WAIT: if (bus.mem_rd_valid) begin
                    bus.block[beat*WORD_WIDTH +: WORD_WIDTH] <= bus.mem_rd_data;
                    if (beat == last_beat) begin
                        state <= WRITE;
                        bus.update_start <= 1'b1;
                    end else begin
                        state <= REQ;
                        beat <= beat + 1'b1;
                        bus.mem_rd_req <= 1'b1;
                        bus.mem_rd_addr <= bus.mem_rd_addr + ADDR_WIDTH'(WORD_WIDTH / 8);
                    end
                end
`ifdef FILL_TIMEOUT_EN
                else if (timer == 8'hFF) begin
                    // same beat, same address: just reissue the read
                    state <= REQ;
                    bus.mem_rd_req <= 1'b1;
                end else
                    timer <= timer + 8'd1;
`endif
                WRITE: if (bus.updated) begin
                    state <= DONE;
                    bus.update_start <= 1'b0;
                    bus.fill_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                    bus.fill_count <= bus.fill_count + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_miss_block_fetch.sv
// tb_miss_block_fetch: directed bench with zero-wait memory and delayed-ack updater models.
module tb_miss_block_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int upd_delay = 2;
    int ucnt = 0;
    int us_cnt = 0;
    int fd_cnt = 0;
    bit mode = 1'b0;
    bit drop = 1'b0;
    bit pend = 1'b0;
    logic [31:0] pdata = '0;
    logic [31:0] addr_log[$];

    miss_block_fetch_if b ();
    miss_block_fetch dut (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_miss(input logic [31:0] a);
        b.miss_addr = a;
        b.miss_req = 1'b1;
        tick();
        b.miss_req = 1'b0;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        us_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (b.busy === 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("idle_wait", 128'(b.busy), 128'd0);
    endtask

    // memory: data appears the cycle after each one-cycle read request
    initial begin
        b.mem_rd_valid = 1'b0;
        b.mem_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            b.mem_rd_valid = pend;
            b.mem_rd_data = pdata;
            if (rst) pend = 1'b0;
            else if (b.mem_rd_req && drop && b.mem_rd_addr[3:2] == 2'd1) begin
                drop = 1'b0;
                pend = 1'b0;
            end else begin
                pend = b.mem_rd_req;
                pdata = mode ? (b.mem_rd_addr ^ 32'hA5A5_0000) : 32'hA0 + 32'(b.mem_rd_addr[3:2]);
            end
        end
    end

    initial begin
        b.updated = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ucnt = b.update_start ? ucnt + 1 : 0;
            b.updated = b.update_start && ucnt == upd_delay + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (b.mem_rd_req) addr_log.push_back(b.mem_rd_addr);
            if (b.update_start) us_cnt++;
            if (b.fill_done) begin
                fd_cnt++;
                chk("done_us_low", 128'(b.update_start), 128'd0);
                chk("done_busy", 128'(b.busy), 128'd1);
            end
        end
    end

    initial begin
        b.miss_req = 1'b0;
        b.miss_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", 128'(b.busy), 128'd0);
        chk("rst_req", 128'(b.mem_rd_req), 128'd0);
        chk("rst_us", 128'(b.update_start), 128'd0);
        chk("rst_block", b.block, 128'd0);
        chk("rst_count", 128'(b.fill_count), 128'd0);
        chk("rst_lat", 128'(b.miss_latency), 128'd0);

        clear_logs();
        do_miss(32'h0000_1234);
        chk("acc_busy", 128'(b.busy), 128'd1);
        chk("acc_req", 128'(b.mem_rd_req), 128'd1);
        wait_idle(200);
        chk("basic_nreq", 128'(addr_log.size()), 128'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk($sformatf("basic_addr%0d", i), 128'(addr_log[i]), 128'(32'h1230 + 32'(4 * i)));
        chk("basic_block", b.block, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("basic_lat", 128'(b.miss_latency), 128'd11);
        chk("basic_count", 128'(b.fill_count), 128'd1);
        chk("basic_fd", 128'(fd_cnt), 128'd1);

        mode = 1'b1;
        clear_logs();
        do_miss(32'h0000_2000);
        tick();
        b.miss_addr = 32'h0000_5550;
        b.miss_req = 1'b1;
        tick();
        b.miss_req = 1'b0;
        wait_idle(200);
        chk("drop_nreq", 128'(addr_log.size()), 128'd4);
        chk("drop_addr3", 128'(addr_log.size() > 3 ? addr_log[3] : 32'h0), 128'h200C);
        chk("drop_block", b.block, 128'hA5A5200C_A5A52008_A5A52004_A5A52000);
        chk("drop_count", 128'(b.fill_count), 128'd2);
        tick();
        chk("drop_idle", 128'(b.busy), 128'd0);

        clear_logs();
        do_miss(32'h0000_3000);
        for (int n = 0; n < 50 && addr_log.size() < 3; n++) tick();
        chk("rstmid_beat2", 128'(addr_log.size()), 128'd3);
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 128'(b.busy), 128'd0);
        chk("rstmid_addr", 128'(b.mem_rd_addr), 128'd0);
        chk("rstmid_block", b.block, 128'd0);
        chk("rstmid_count", 128'(b.fill_count), 128'd0);
        chk("rstmid_lat", 128'(b.miss_latency), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_us", 128'(b.update_start), 128'd0);
        chk("rstmid_fd", 128'(fd_cnt), 128'd0);
        clear_logs();
        do_miss(32'h0000_4444);
        wait_idle(200);
        chk("refill_block", b.block, 128'hA5A5444C_A5A54448_A5A54444_A5A54440);
        chk("refill_lat", 128'(b.miss_latency), 128'd11);
        chk("refill_count", 128'(b.fill_count), 128'd1);

        clear_logs();
        do_miss(32'h0000_1100);
        wait_idle(200);
        do_miss(32'h0000_2200);
        chk("b2b_acc", 128'(b.busy), 128'd1);
        wait_idle(200);
        chk("b2b_block", b.block, 128'hA5A5220C_A5A52208_A5A52204_A5A52200);
        chk("b2b_count", 128'(b.fill_count), 128'd3);
        chk("b2b_fd", 128'(fd_cnt), 128'd2);
        chk("b2b_nreq", 128'(addr_log.size()), 128'd8);

        upd_delay = 20;
        clear_logs();
        do_miss(32'h0000_7000);
        wait_idle(200);
        chk("hs_us_cycles", 128'(us_cnt), 128'd21);
        chk("hs_fd", 128'(fd_cnt), 128'd1);
        chk("hs_lat", 128'(b.miss_latency), 128'd29);
        chk("hs_count", 128'(b.fill_count), 128'd4);
        upd_delay = 2;

`ifdef FILL_TIMEOUT_EN
        drop = 1'b1;
        clear_logs();
        do_miss(32'h0000_6000);
        wait_idle(1000);
        chk("to_nreq", 128'(addr_log.size()), 128'd5);
        chk("to_reissue", 128'(addr_log.size() > 2 ? addr_log[2] : 32'h0), 128'h6004);
        chk("to_lat", 128'(b.miss_latency), 128'd268);
        chk("to_block", b.block, 128'hA5A5600C_A5A56008_A5A56004_A5A56000);
        chk("to_count", 128'(b.fill_count), 128'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
